// File: rtl/csa_seq_add_ctrl.sv
// csa_seq_add_ctrl
// Sequential WIDTH-bit adder controller: one shared 4-bit carry-select slice
// is stepped across the operands, one nibble per clock, LSB nibble first.
// The inter-nibble carry lives in a register.
// Operands arrive on an in_valid/in_ready handshake. The result leaves on an
// out_valid/out_ready handshake.
// Optional feature: define CSA_SEQ_OVF_EN to add the signed-overflow output ovf.
module csa_seq_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef CSA_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              out_valid_q, out_valid_d;
`ifdef CSA_SEQ_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [3:0]        slice_a;
    logic [3:0]        slice_b;
    logic [4:0]        slice_c0;
    logic [4:0]        slice_c1;
    logic [4:0]        slice_res;

    // Select the operand nibbles addressed by idx for the shared slice.
    always_comb begin
        slice_a = 4'd0;
        slice_b = 4'd0;
        for (int n = 0; n < NIB; n++) begin
            if (idx_q == IDXW'(n)) begin
                slice_a = a_q[4*n +: 4];
                slice_b = b_q[4*n +: 4];
            end
        end
    end

    // Carry-select slice: both carry-in cases are precomputed, and the registered carry picks one.
    always_comb begin
        slice_c0  = {1'b0, slice_a} + {1'b0, slice_b};
        slice_c1  = {1'b0, slice_a} + {1'b0, slice_b} + 5'd1;
        slice_res = carry_q ? slice_c1 : slice_c0;
    end

    // Next-state logic and datapath updates for IDLE/RUN/DONE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
`ifdef CSA_SEQ_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NIB; n++) begin
                    if (idx_q == IDXW'(n)) begin
                        sum_d[4*n +: 4] = slice_res[3:0];
                    end
                end
                carry_d = slice_res[4];
                if (idx_q == LAST_IDX) begin
                    cout_d      = slice_res[4];
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = DONE;
`ifdef CSA_SEQ_OVF_EN
                    // Carry into the MSB is recovered from the sum bit and the operand bits.
                    ovf_d       = (slice_a[3] ^ slice_b[3] ^ slice_res[3]) ^ slice_res[4];
`endif
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CSA_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef CSA_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // in_ready is gated by rst_n, so it stays low while reset is held even though the state is IDLE.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CSA_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_csa_seq_add_ctrl.sv
// Testbench for csa_seq_add_ctrl (WIDTH=16). Define CSA_SEQ_OVF_EN to also test ovf.
module tb_csa_seq_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        cin_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef CSA_SEQ_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] res_sum;
    logic        res_cout;
    logic        res_ovf;
    int          res_lat;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        c;
    } vec_t;

    vec_t vecs [8];

    csa_seq_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef CSA_SEQ_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Present operands, take the accept edge, then wait until out_valid rises.
    task automatic start_and_wait(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
        int  n;
        logic ready_seen;
        @(negedge clk);
        a_i = ta; b_i = tb; cin_i = tc; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
            in_valid = 1'b0;
            res_lat = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble the inputs to confirm operands were latched on accept.
        in_valid = 1'b0; a_i = ~ta; b_i = 16'h5A5A; cin_i = ~tc;
        n = 0;
        ready_seen = 1'b0;
        while (!out_valid && n < 50) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        res_lat  = n;
        res_sum  = sum;
        res_cout = cout;
`ifdef CSA_SEQ_OVF_EN
        res_ovf  = ovf;
`else
        res_ovf  = 1'b0;
`endif
        check("in_ready_low_run", {31'd0, ready_seen}, 32'd0);
        check("in_ready_low_done", {31'd0, in_ready}, 32'd0);
        check("busy_done", {31'd0, busy}, 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_cleared", {31'd0, out_valid}, 32'd0);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
        start_and_wait(ta, tb, tc);
        release_result();
        $display("op %h + %h + %0d -> sum=%h cout=%0d ovf=%0d lat=%0d", ta, tb, tc, res_sum, res_cout, res_ovf, res_lat);
    endtask

    initial begin
        int acc_k [2];
        int xfer_k [2];
        logic [15:0] bb_sum [2];
        logic        bb_cout [2];
        int na;
        int nx;
        logic acc;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_i = '0; b_i = '0; cin_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("vec%0d_sum", i), {16'd0, res_sum}, {16'd0, vecs[i].s});
            check($sformatf("vec%0d_cout", i), {31'd0, res_cout}, {31'd0, vecs[i].c});
            check($sformatf("vec%0d_lat", i), res_lat, 32'd4);
        end

        // Backpressure: result held, new operands refused.
        start_and_wait(16'h1111, 16'h2222, 1'b0);
        in_valid = 1'b1; a_i = 16'hFFFF; b_i = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d_sum", i), {16'd0, sum}, 32'h3333);
            check($sformatf("bp%0d_cout", i), {31'd0, cout}, 32'd0);
            check($sformatf("bp%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        release_result();
        check("bp_busy_after", {31'd0, busy}, 32'd0);
        $display("op backpressure 1111 + 2222 -> sum=%h held 6 cycles", res_sum);

        // Back-to-back with in_valid held high
        @(negedge clk);
        na = 0; nx = 0;
        a_i = 16'h00FF; b_i = 16'h0F01; cin_i = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (out_valid && out_ready && nx < 2) begin
                bb_sum[nx] = sum; bb_cout[nx] = cout; xfer_k[nx] = k; nx++;
            end
            acc = in_valid && in_ready;
            if (acc && na < 2) begin
                acc_k[na] = k; na++;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                if (na == 1) begin
                    a_i = 16'h8001; b_i = 16'h8000; cin_i = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (nx == 2) break;
        end
        out_ready = 1'b0;
        check("b2b_accepts", na, 32'd2);
        check("b2b_xfers", nx, 32'd2);
        if (na == 2 && nx == 2) begin
            check("b2b_sum0", {16'd0, bb_sum[0]}, 32'h1000);
            check("b2b_cout0", {31'd0, bb_cout[0]}, 32'd0);
            check("b2b_sum1", {16'd0, bb_sum[1]}, 32'h0002);
            check("b2b_cout1", {31'd0, bb_cout[1]}, 32'd1);
            check("b2b_first_lat", xfer_k[0] - acc_k[0], 32'd5);
            check("b2b_second_accept", acc_k[1], xfer_k[0] + 1);
            $display("op back-to-back sums=%h,%h accepts@%0d,%0d xfer@%0d,%0d",
                     bb_sum[0], bb_sum[1], acc_k[0], acc_k[1], xfer_k[0], xfer_k[1]);
        end

        // Reset during the second RUN cycle
        @(negedge clk);
        a_i = 16'hAAAA; b_i = 16'h5555; cin_i = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        check("mid_partial_sum", {16'd0, sum}, 32'h000F);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("abort_in_ready_hold", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        $display("op reset abort of AAAA + 5555");
        do_op(16'h0F0F, 16'h0101, 1'b0);
        check("post_abort_sum", {16'd0, res_sum}, 32'h1010);
        check("post_abort_cout", {31'd0, res_cout}, 32'd0);
        check("post_abort_lat", res_lat, 32'd4);

`ifdef CSA_SEQ_OVF_EN
        do_op(16'h7FFF, 16'h0001, 1'b0);
        check("ovf1_sum", {16'd0, res_sum}, 32'h8000);
        check("ovf1_ovf", {31'd0, res_ovf}, 32'd1);
        check("ovf1_cout", {31'd0, res_cout}, 32'd0);
        do_op(16'h8000, 16'h8000, 1'b0);
        check("ovf2_sum", {16'd0, res_sum}, 32'h0000);
        check("ovf2_ovf", {31'd0, res_ovf}, 32'd1);
        check("ovf2_cout", {31'd0, res_cout}, 32'd1);
        do_op(16'h0001, 16'h0001, 1'b0);
        check("ovf3_sum", {16'd0, res_sum}, 32'h0002);
        check("ovf3_ovf", {31'd0, res_ovf}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_seq_add_ctrl.md
Name: csa_seq_add_ctrl

Overview:
Sequencing controller that performs a WIDTH-bit addition by stepping one shared 4-bit carry-select adder slice across the operands, one nibble per clock, LSB first. It holds the inter-nibble carry in a register. It accepts operands over a valid/ready input handshake and returns the sum over a valid/ready output handshake. It sits between a requester and the 4-bit carry-select datapath and trades latency for area on wide adds.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
NIB, WIDTH/4 (derived, localparam), number of slice passes per operation.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand set valid.
in_ready  output  1  controller can accept operands.
a  input  WIDTH  operand A; sampled on the accept edge.
b  input  WIDTH  operand B; sampled on the accept edge.
cin  input  1  carry-in to nibble 0; sampled on the accept edge.
out_valid  output  1  sum/cout valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  registered result.
cout  output  1  carry out of the MSB nibble.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; idx=0; carry=0; sum=0; cout=0; out_valid=0; busy=0; internal operand registers=0.
- in_ready is 1 only in IDLE and is 0 during reset.
- Clock and reset ports are named clk and rst_n: one clock, asynchronous active-low reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Accept occurs on a clock edge where in_valid && in_ready.
  - On accept: latch a, b; carry<=cin; idx<=0; sum<=0; go to RUN.
  - Without in_valid: stay in IDLE.
- RUN, each cycle:
  - Slice inputs: A=a_r[4*idx+:4], B=b_r[4*idx+:4], Cin=carry.
  - Slice computes both the carry=0 and carry=1 4-bit results and selects one by carry.
  - Update: sum[4*idx+:4]<=slice sum; carry<=slice carry-out; idx<=idx+1.
  - When idx==NIB-1: cout<=slice carry-out; out_valid<=1; idx<=0; go to DONE.
- DONE:
  - sum, cout and out_valid held stable until out_ready=1.
  - Edge with out_valid && out_ready: out_valid<=0; go to IDLE.
  - in_ready is 0 throughout DONE, so no new accept can occur on the same edge as a result transfer. Next accept is possible one cycle later.
- Latency: out_valid rises exactly NIB clock edges after the accept edge. Throughput is at most one operation per NIB+2 cycles.
- Operands are latched on accept. Changes to a, b or cin after the accept edge do not affect the result.
- Arithmetic: unsigned modulo 2^WIDTH; {cout,sum} = a + b + cin, exact in WIDTH+1 bits.
- WIDTH=4 (NIB=1): RUN lasts one cycle; same rules apply.
- idx width is clog2(NIB), minimum 1 bit. idx never exceeds NIB-1.
- Reset asserted mid-RUN or in DONE: operation aborted with no output; all state returns to reset values immediately.
- Reset release: first accept is possible on the first clock edge after rst_n goes high.

Optional Feature:
Macro CSA_SEQ_OVF_EN.
- Defined: adds output port ovf (1 bit).
  - ovf = carry into bit WIDTH-1 XOR cout, i.e. two's-complement signed overflow.
  - Registered with cout, same timing; reset to 0; held in DONE.
- Undefined: no ovf port and no extra logic; all other behaviour identical.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid high exactly 4 edges after accept; in_ready=0 until the handshake completes.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 nibbles). Then a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
3. Backpressure: hold out_ready=0 for 6 cycles after out_valid. Required: sum, cout and out_valid stable; in_ready=0; and in_valid=1 with new operands must not be accepted. Release out_ready -> IDLE next edge.
4. Back-to-back: in_valid held high with two operand sets, out_ready=1 throughout -> two correct results; second accept occurs one cycle after the first out_valid && out_ready edge.
5. Reset mid-op: accept 0xAAAA+0x5555, assert rst_n=0 at the 2nd RUN cycle -> all outputs 0 immediately, in_ready=0 during reset. After release, accept 0x0F0F+0x0101 -> sum=0x1010, cout=0.
6. With CSA_SEQ_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0. 0x8000+0x8000 -> sum=0x0000, ovf=1, cout=1. 0x0001+0x0001 -> ovf=0.
